// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and constants for the adder BIST controller
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_CHECK,
        ST_DONE
    } bist_state_t;

    localparam int MISR_W = 6;
    // x^6 + x^5 + 1: feedback is misr[5] ^ misr[4]
    localparam logic [MISR_W-1:0] MISR_TAPS = 6'b110000;

    localparam int LFSR_W      = 33;
    localparam int LFSR_TAP_HI = 32;
    localparam int LFSR_TAP_LO = 19;

    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] misr,
                                                    input logic [MISR_W-1:0] din);
        misr_next = {misr[MISR_W-2:0], ^(misr & MISR_TAPS)} ^ din;
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// rtl/bist_lfsr.sv - Fibonacci LFSR pattern generator, x^33 + x^20 + 1
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int                W    = LFSR_W,
    parameter logic [W-1:0]      SEED = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] state
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (step) begin
            state <= {state[W-2:0], state[LFSR_TAP_HI] ^ state[LFSR_TAP_LO]};
        end
    end

endmodule

// File: rtl/bist_ctrl.sv
// rtl/bist_ctrl.sv - BIST sequencer with LFSR patterns and MISR signature; BIST_ABORT_EN adds abort input
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int                    N       = 16,
    parameter int                    PAT_CNT = 256,
    parameter logic [2*N:0]          SEED    = 33'h0_FFFF_0000,
    parameter logic [MISR_W-1:0]     GOLDEN  = 6'h00
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef BIST_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    output logic [N-1:0]      pat_a,
    output logic [N-1:0]      pat_b,
    output logic              pat_ci,
    input  logic [MISR_W-1:0] com_res,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] sig
);

    localparam int W     = 2 * N + 1;
    localparam int CNT_W = $clog2(PAT_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAT_CNT - 1);

    bist_state_t       state;
    logic [MISR_W-1:0] misr;
    logic [CNT_W-1:0]  cnt;
    logic [W-1:0]      lfsr_state;
    logic              abort_hit;

`ifdef BIST_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // An abort freezes the pattern source along with the signature.
    bist_lfsr #(.W(W), .SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  ((state == ST_SEED) && !abort_hit),
        .step  ((state == ST_RUN) && !abort_hit),
        .state (lfsr_state)
    );

    assign {pat_ci, pat_a, pat_b} = lfsr_state;
    assign sig = misr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            misr  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else if (busy && abort_hit) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_SEED;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                ST_SEED: begin
                    misr  <= '0;
                    cnt   <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    misr <= misr_next(misr, com_res);
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    pass  <= (misr == GOLDEN);
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_ctrl.sv
// tb/tb_bist_ctrl.sv - directed self-checking bench for bist_ctrl
module tb_bist_ctrl;

    localparam logic [32:0] SEED_V = 33'h0_FFFF_0000;

    logic clk;
    logic rst_n;

    logic        start1, start2, start3;
    logic [5:0]  com1, com2, com3;
    logic [15:0] pat_a1, pat_b1, pat_a2, pat_b2, pat_a3, pat_b3;
    logic        pat_ci1, pat_ci2, pat_ci3;
    logic        busy1, done1, pass1, busy2, done2, pass2, busy3, done3, pass3;
    logic [5:0]  sig1, sig2, sig3;
`ifdef BIST_ABORT_EN
    logic        abort1, abort2, abort3;
`endif

    int checks = 0;
    int errors = 0;

    bist_ctrl #(.PAT_CNT(1), .GOLDEN(6'h22)) u_one (
        .clk(clk), .rst_n(rst_n),
`ifdef BIST_ABORT_EN
        .abort(abort1),
`endif
        .start(start1), .pat_a(pat_a1), .pat_b(pat_b1), .pat_ci(pat_ci1),
        .com_res(com1), .busy(busy1), .done(done1), .pass(pass1), .sig(sig1)
    );

    bist_ctrl #(.PAT_CNT(2), .GOLDEN(6'h16)) u_two (
        .clk(clk), .rst_n(rst_n),
`ifdef BIST_ABORT_EN
        .abort(abort2),
`endif
        .start(start2), .pat_a(pat_a2), .pat_b(pat_b2), .pat_ci(pat_ci2),
        .com_res(com2), .busy(busy2), .done(done2), .pass(pass2), .sig(sig2)
    );

    bist_ctrl u_full (
        .clk(clk), .rst_n(rst_n),
`ifdef BIST_ABORT_EN
        .abort(abort3),
`endif
        .start(start3), .pat_a(pat_a3), .pat_b(pat_b3), .pat_ci(pat_ci3),
        .com_res(com3), .busy(busy3), .done(done3), .pass(pass3), .sig(sig3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] mshift(input logic [5:0] m);
        return {m[4:0], m[5] ^ m[4]};
    endfunction

    function automatic logic [32:0] lstep(input logic [32:0] l);
        return {l[31:0], l[32] ^ l[19]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_full(input int abort_at, input logic [5:0] target);
        logic [5:0]  m;
        logic [32:0] l;
        logic [5:0]  c;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("full_busy_seed", 33'(busy3), 33'd1);
        tick();
        m = 6'h00;
        l = SEED_V;
        for (int k = 0; k < 256; k++) begin
            check($sformatf("full_pat_k%0d", k), {pat_ci3, pat_a3, pat_b3}, l);
            c = (k == 255) ? (mshift(m) ^ target) : 6'(k * 7 + 3);
            com3   = c;
            start3 = (k == 100);
`ifdef BIST_ABORT_EN
            if (k == abort_at) begin
                abort3 = 1'b1;
                tick();
                abort3 = 1'b0;
                check("abort_done", 33'(done3), 33'd1);
                check("abort_busy", 33'(busy3), 33'd0);
                check("abort_pass", 33'(pass3), 33'd0);
                check("abort_sig", 33'(sig3), 33'(m));
                return;
            end
`endif
            tick();
            m = mshift(m) ^ c;
            l = lstep(l);
        end
        start3 = 1'b0;
        check("full_check_busy", 33'(busy3), 33'd1);
        check("full_check_done", 33'(done3), 33'd0);
        check("full_sig", 33'(sig3), 33'(target));
        tick();
        check("full_done", 33'(done3), 33'd1);
        check("full_done_busy", 33'(busy3), 33'd0);
        check("full_pass", 33'(pass3), 33'(target == 6'h00));
    endtask

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        com1 = '0; com2 = '0; com3 = '0;
`ifdef BIST_ABORT_EN
        abort1 = 1'b0; abort2 = 1'b0; abort3 = 1'b0;
`endif
        tick();
        tick();
        check("rst_busy", 33'(busy1), 33'd0);
        check("rst_done", 33'(done1), 33'd0);
        check("rst_pass", 33'(pass1), 33'd0);
        check("rst_sig", 33'(sig1), 33'd0);
        check("rst_pat", {pat_ci1, pat_a1, pat_b1}, SEED_V);
        rst_n = 1'b1;
        tick();

        // single pattern, signature matches golden
        start1 = 1'b1;
        com1   = 6'h22;
        tick();
        start1 = 1'b0;
        check("one_seed_busy", 33'(busy1), 33'd1);
        tick();
        check("one_run_pat", {pat_ci1, pat_a1, pat_b1}, SEED_V);
        tick();
        check("one_check_sig", 33'(sig1), 33'h22);
        check("one_check_done", 33'(done1), 33'd0);
        tick();
        check("one_done", 33'(done1), 33'd1);
        check("one_done_busy", 33'(busy1), 33'd0);
        check("one_pass", 33'(pass1), 33'd1);
        tick();
        tick();
        check("one_hold_done", 33'(done1), 33'd1);
        check("one_hold_sig", 33'(sig1), 33'h22);

        // rerun from DONE with a mismatching signature
        start1 = 1'b1;
        com1   = 6'h13;
        tick();
        start1 = 1'b0;
        check("rerun_pass_clr", 33'(pass1), 33'd0);
        check("rerun_done_clr", 33'(done1), 33'd0);
        tick();
        tick();
        tick();
        check("rerun_done", 33'(done1), 33'd1);
        check("rerun_pass", 33'(pass1), 33'd0);
        check("rerun_sig", 33'(sig1), 33'h13);

        // two patterns: 0x22 then 0x13 folds to 0x16
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        com2 = 6'h22;
        tick();
        check("two_pat1", {pat_ci2, pat_a2, pat_b2}, 33'h1_FFFE_0001);
        com2 = 6'h13;
        tick();
        check("two_sig", 33'(sig2), 33'h16);
        tick();
        check("two_done", 33'(done2), 33'd1);
        check("two_pass", 33'(pass2), 33'd1);

        // reset in RUN cycle 5, together with start: reset wins
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            com3 = 6'(k + 1);
            tick();
        end
        check("mid_busy", 33'(busy3), 33'd1);
        rst_n  = 1'b0;
        start3 = 1'b1;
        tick();
        check("mrst_busy", 33'(busy3), 33'd0);
        check("mrst_done", 33'(done3), 33'd0);
        check("mrst_sig", 33'(sig3), 33'd0);
        check("mrst_pat", {pat_ci3, pat_a3, pat_b3}, SEED_V);
        rst_n  = 1'b1;
        start3 = 1'b0;
        tick();
        check("mrst_idle", 33'(busy3), 33'd0);

        run_full(-1, 6'h00);
        run_full(-1, 6'h15);
`ifdef BIST_ABORT_EN
        run_full(10, 6'h00);
        run_full(-1, 6'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
